// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 Hz VGA raster timing generator
//
// Purpose: divides CLK down to the pixel rate, walks the horizontal and
// vertical raster counters, exposes the (down-shifted) pixel address to the
// drawing logic and registers the returned colour together with the syncs.
//
// Ports:
//   CLK         system clock (100 MHz)
//   RESET       asynchronous, active-high reset
//   COLOUR_IN   colour for the pixel currently on X_ADDR/Y_ADDR
//   X_ADDR      visible column >> ADDR_SHIFT, 0 outside the visible area
//   Y_ADDR      visible line >> ADDR_SHIFT, 0 outside the visible area
//   COLOUR_OUT  registered colour to the DAC pins (black while blanking)
//   HS, VS      horizontal / vertical sync, active level SYNC_POL
//   FRAME_TICK  one-CLK pulse on the last pixel clock of each frame
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int ADDR_SHIFT = 2,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] COLOUR_IN,
  output logic [9:0]  X_ADDR,
  output logic [8:0]  Y_ADDR,
  output logic [11:0] COLOUR_OUT,
  output logic        HS,
  output logic        VS,
  output logic        FRAME_TICK
);

  localparam int PS_W = $clog2(CLK_DIV);

  localparam logic [PS_W-1:0] PS_MAX   = PS_W'(CLK_DIV - 1);
  localparam logic [9:0] H_VIS_C       = 10'(H_VIS);
  localparam logic [9:0] H_LAST        = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_SYNC_FIRST  = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_LAST   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS_C       = 10'(V_VIS);
  localparam logic [9:0] V_LAST        = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_SYNC_FIRST  = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_LAST   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [PS_W-1:0] ps;
  logic [9:0]      hcount;
  logic [9:0]      vcount;
  logic            pix_en;
  logic            h_end;
  logic            v_end;
  logic            visible;
  logic            hs_active;
  logic            vs_active;

  assign pix_en    = (ps == PS_MAX);
  assign h_end     = (hcount == H_LAST);
  assign v_end     = (vcount == V_LAST);
  assign visible   = (hcount < H_VIS_C) && (vcount < V_VIS_C);
  assign hs_active = (hcount >= H_SYNC_FIRST) && (hcount <= H_SYNC_LAST);
  assign vs_active = (vcount >= V_SYNC_FIRST) && (vcount <= V_SYNC_LAST);

  // Address decode comes straight off the registered counters, so it only
  // changes on pixel boundaries and holds for the full CLK_DIV cycles the
  // colour source is allowed to take.
  assign X_ADDR = visible ? (hcount >> ADDR_SHIFT) : 10'd0;
  assign Y_ADDR = visible ? 9'(vcount >> ADDR_SHIFT) : 9'd0;

  // Combinational so the pulse lands in the very cycle the frame wraps.
  assign FRAME_TICK = pix_en && h_end && v_end;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ps <= '0;
    end else if (pix_en) begin
      ps <= '0;
    end else begin
      ps <= ps + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else if (pix_en) begin
      if (h_end) begin
        hcount <= 10'd0;
        vcount <= v_end ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Colour and syncs are captured at the end of each pixel, which puts all
  // three one pixel period behind the address bus and aligned to each other.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COLOUR_OUT <= 12'h000;
      HS         <= ~SYNC_POL;
      VS         <= ~SYNC_POL;
    end else if (pix_en) begin
      COLOUR_OUT <= visible ? COLOUR_IN : 12'h000;
      HS         <= hs_active ? SYNC_POL : ~SYNC_POL;
      VS         <= vs_active ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - testbench for vga_timing_gen
module tb_vga_timing_gen;

  // Shrunken raster so whole frames fit in a short run.
  localparam int CDIV = 4;
  localparam int HV = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] colour_in;
  logic [11:0] colour_full;

  logic [9:0]  s_x, f_x;
  logic [8:0]  s_y, f_y;
  logic [11:0] s_col, f_col;
  logic        s_hs, s_vs, s_ft, f_hs, f_vs, f_ft;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], ticks[$];
  int fhs_fall[$], fhs_rise[$];
  int max_x, max_y;
  logic prev_hs, prev_vs, prev_fhs;

  vga_timing_gen #(
    .CLK_DIV(CDIV), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .ADDR_SHIFT(2), .SYNC_POL(1'b0)
  ) dut (
    .CLK(clk), .RESET(rst), .COLOUR_IN(colour_in),
    .X_ADDR(s_x), .Y_ADDR(s_y), .COLOUR_OUT(s_col),
    .HS(s_hs), .VS(s_vs), .FRAME_TICK(s_ft)
  );

  vga_timing_gen dut_full (
    .CLK(clk), .RESET(rst), .COLOUR_IN(colour_full),
    .X_ADDR(f_x), .Y_ADDR(f_y), .COLOUR_OUT(f_col),
    .HS(f_hs), .VS(f_vs), .FRAME_TICK(f_ft)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int colour_of(input int x, input int y);
    return (x % 16) * 256 + (y % 16) * 16 + 10;
  endfunction

  // Model: the raster position is simply (edges / CLK_DIV) laid out over an
  // HT x VT grid; registered outputs reflect the previous pixel.
  task automatic step();
    int p, h, v, ph, pv, ex, ey, ec, ehs, evs, eft;
    bit vis, pvis;
    vis = 1'b0;
    if (rst) begin
      ex = 0; ey = 0; ec = 0; ehs = 1; evs = 1; eft = 0;
    end else begin
      p   = n / CDIV;
      h   = p % HT;
      v   = (p / HT) % VT;
      vis = (h < HV) && (v < VV);
      ex  = vis ? h / 4 : 0;
      ey  = vis ? v / 4 : 0;
      eft = (n % CDIV == CDIV - 1) && (h == HT - 1) && (v == VT - 1);
      if (p == 0) begin
        ec = 0; ehs = 1; evs = 1;
      end else begin
        ph   = (p - 1) % HT;
        pv   = ((p - 1) / HT) % VT;
        pvis = (ph < HV) && (pv < VV);
        ec   = pvis ? colour_of(ph / 4, pv / 4) : 0;
        ehs  = (ph >= HV + HF && ph < HV + HF + HSW) ? 0 : 1;
        evs  = (pv >= VV + VF && pv < VV + VF + VSW) ? 0 : 1;
      end
    end
    check("x_addr", int'(s_x), ex);
    check("y_addr", int'(s_y), ey);
    check("colour_out", int'(s_col), ec);
    check("hs", int'(s_hs), ehs);
    check("vs", int'(s_vs), evs);
    check("frame_tick", int'(s_ft), eft);

    if (!rst) begin
      if (prev_hs && !s_hs)   hs_fall.push_back(n);
      if (!prev_hs && s_hs)   hs_rise.push_back(n);
      if (prev_vs && !s_vs)   vs_fall.push_back(n);
      if (!prev_vs && s_vs)   vs_rise.push_back(n);
      if (prev_fhs && !f_hs)  fhs_fall.push_back(n);
      if (!prev_fhs && f_hs)  fhs_rise.push_back(n);
      if (s_ft)               ticks.push_back(n);
      if (int'(s_x) > max_x)  max_x = int'(s_x);
      if (int'(s_y) > max_y)  max_y = int'(s_y);
      if (n == 15) check("full_x_pixel3", int'(f_x), 0);
      if (n == 16) check("full_x_pixel4", int'(f_x), 1);
    end
    prev_hs  = s_hs;
    prev_vs  = s_vs;
    prev_fhs = f_hs;

    colour_in = vis ? 12'(colour_of(ex, ey)) : 12'hFFF;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic clear_events();
    hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
    ticks.delete(); fhs_fall.delete(); fhs_rise.delete();
    max_x = 0; max_y = 0;
  endtask

  initial begin
    rst = 1'b1;
    colour_in = 12'hFFF;
    colour_full = 12'h5A5;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_fhs = 1'b1;
    clear_events();

    run(3);
    check("full_hs_reset", int'(f_hs), 1);
    check("full_col_reset", int'(f_col), 0);

    #1 rst = 1'b0;
    run(3800);

    // Hand-computed edge numbers for the shrunken raster and the real one.
    check("tick_count", ticks.size(), 2);
    check("first_tick", first(ticks), 1727);
    check("tick_period", (ticks.size() > 1) ? ticks[1] - ticks[0] : -1, 1728);
    check("hs_fall", first(hs_fall), 76);
    check("hs_rise", first(hs_rise), 88);
    check("vs_fall", first(vs_fall), 1348);
    check("vs_rise", first(vs_rise), 1540);
    check("max_x", max_x, 3);
    check("max_y", max_y, 2);
    check("full_hs_fall", first(fhs_fall), 2628);
    check("full_hs_width", first(fhs_rise) - first(fhs_fall), 384);

    // Land inside the second line's HS pulse of the full-size instance.
    run(2100);
    check("full_hs_pre_reset", int'(f_hs), 0);
    check("col_pre_reset", int'(s_col), colour_of(2, 1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_full_hs", int'(f_hs), 1);
    check("async_hs", int'(s_hs), 1);
    check("async_col", int'(s_col), 0);
    check("async_x", int'(s_x), 0);
    check("async_tick", int'(s_ft), 0);

    clear_events();
    run(3);
    #1 rst = 1'b0;
    run(3100);
    check("restart_full_hs_fall", first(fhs_fall), 2628);
    check("restart_full_hs_rise", first(fhs_rise), 3012);
    check("restart_hs_fall", first(hs_fall), 76);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
